// File: rtl/mem_resp_stage.sv
// ---------------------------------------------------------------------------
// mem_resp_stage
//
// Memory-response stage of the five-stage MIPS pipeline, between EX and WB.
// Holds up to DEPTH in-order instructions whose data-SRAM requests are
// outstanding. It captures data_ok responses even while WB stalls, and it
// extracts load results (LW/LB/LBU/LH/LHU/LWL/LWR) for each entry.
// A flush discards every queued entry. Responses the memory still owes for
// flushed instructions are then absorbed silently through drop_cnt.
//
// Parameters
//   DEPTH   queue entries (power of two, >= 2)
//   CTRL_W  opaque side-band width, passed through untouched
//
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   es_to_ms_valid/ms_allowin  EX -> stage handshake
//   in_*                    instruction fields offered by EX
//   flush                   kill all entries (exception / ERET from WB)
//   data_sram_data_ok/rdata in-order memory responses
//   ms_to_ws_valid/ws_allowin  stage -> WB handshake
//   out_*                   head entry fields (zero when not valid)
//   MEM_dest*               forwarding of the youngest writing entry
//
// Configuration macro
//   MEM_FWD_EN  when defined, MEM_dest/MEM_dest_data/MEM_dest_ok forward the
//               youngest valid register-writing entry. When undefined, all
//               three are tied to zero.
// ---------------------------------------------------------------------------
module mem_resp_stage #(
    parameter int DEPTH  = 4,
    parameter int CTRL_W = 71
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              es_to_ms_valid,
    output logic              ms_allowin,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [4:0]        in_dest,
    input  logic              in_gr_we,
    input  logic [31:0]       in_alu_result,
    input  logic              in_mem_access,
    input  logic              in_res_from_mem,
    input  logic [2:0]        in_load_op,
    input  logic [31:0]       in_rt,
    input  logic              flush,
    input  logic              data_sram_data_ok,
    input  logic [31:0]       data_sram_rdata,
    output logic              ms_to_ws_valid,
    input  logic              ws_allowin,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [4:0]        out_dest,
    output logic              out_gr_we,
    output logic [31:0]       out_result,
    output logic [4:0]        MEM_dest,
    output logic [31:0]       MEM_dest_data,
    output logic              MEM_dest_ok
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_SUM = (CW + 1)'(DEPTH);

    typedef logic [AW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    // Per-entry storage
    logic              valid_q        [DEPTH];
    logic              done_q         [DEPTH];
    logic [CTRL_W-1:0] ctrl_q         [DEPTH];
    logic [4:0]        dest_q         [DEPTH];
    logic              gr_we_q        [DEPTH];
    logic [31:0]       alu_result_q   [DEPTH];
    logic              mem_access_q   [DEPTH];
    logic              res_from_mem_q [DEPTH];
    logic [2:0]        load_op_q      [DEPTH];
    logic [31:0]       rt_q           [DEPTH];
    logic [31:0]       rdata_q        [DEPTH];

    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d;
    cnt_t count_q, count_d;
    cnt_t drop_cnt_q, drop_cnt_d;

    cnt_t pending;
    ptr_t rsp_ptr;
    logic rsp_found;
    ptr_t scan_idx;

    logic head_ready;
    logic accept;
    logic pop;
    logic absorb_drop;
    logic absorb_entry;
    logic offered_mem;

    // Final writeback value of one entry. rd is the stored response word and
    // rt is the old register value used by the unaligned merges.
    function automatic logic [31:0] load_result(
        input logic        from_mem,
        input logic [2:0]  op,
        input logic [31:0] alu,
        input logic [31:0] rd,
        input logic [31:0] rt
    );
        logic [1:0]  ofs;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        ofs = alu[1:0];
        case (ofs)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = ofs[1] ? rd[31:16] : rd[15:0];
        r = alu;
        if (from_mem) begin
            case (op)
                3'd1: r = {{24{b[7]}}, b};
                3'd2: r = {24'd0, b};
                3'd3: r = {{16{h[15]}}, h};
                3'd4: r = {16'd0, h};
                3'd5: begin
                    case (ofs)
                        2'd0:    r = {rd[7:0],  rt[23:0]};
                        2'd1:    r = {rd[15:0], rt[15:0]};
                        2'd2:    r = {rd[23:0], rt[7:0]};
                        default: r = rd;
                    endcase
                end
                3'd6: begin
                    case (ofs)
                        2'd0:    r = rd;
                        2'd1:    r = {rt[31:24], rd[31:8]};
                        2'd2:    r = {rt[31:16], rd[31:16]};
                        default: r = {rt[31:8],  rd[31:24]};
                    endcase
                end
                default: r = rd;
            endcase
        end
        return r;
    endfunction

    // Count entries still owed a response and locate the oldest one.
    // Valid entries are contiguous from rd_ptr. Scanning in age order
    // therefore finds the entry the next non-dropped data_ok belongs to.
    // This also steps over entries that never issued a request.
    always_comb begin
        pending   = '0;
        rsp_ptr   = '0;
        rsp_found = 1'b0;
        scan_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = rd_ptr_q + AW'(i);
            if (valid_q[scan_idx] && mem_access_q[scan_idx] && !done_q[scan_idx]) begin
                pending = pending + cnt_t'(1);
                if (!rsp_found) begin
                    rsp_ptr   = scan_idx;
                    rsp_found = 1'b1;
                end
            end
        end
    end

    // Handshakes. A slot is granted only if the response it may owe fits
    // alongside the responses still to be dropped. The pending + drop total
    // therefore never exceeds DEPTH.
    always_comb begin
        head_ready   = valid_q[rd_ptr_q] && (!mem_access_q[rd_ptr_q] || done_q[rd_ptr_q]);
        ms_allowin   = (count_q < DEPTH_CNT) && (({1'b0, pending} + {1'b0, drop_cnt_q}) < DEPTH_SUM);
        accept       = es_to_ms_valid && ms_allowin && !flush;
        pop          = head_ready && ws_allowin;
        absorb_drop  = data_sram_data_ok && (drop_cnt_q != '0);
        absorb_entry = data_sram_data_ok && (drop_cnt_q == '0) && (pending != '0);
        offered_mem  = es_to_ms_valid && in_mem_access && ms_allowin;
    end

    // Pointer, occupancy and drop-counter next state. On flush, every
    // outstanding request becomes a response to drop. This includes one
    // issued with a same-cycle offer. A response absorbed by a live entry
    // this cycle is no longer owed.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        drop_cnt_d = drop_cnt_q - cnt_t'(absorb_drop);
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            drop_cnt_d = drop_cnt_q - cnt_t'(absorb_drop) + pending
                         + cnt_t'(offered_mem) - cnt_t'(absorb_entry);
        end else begin
            if (accept) wr_ptr_d = wr_ptr_q + ptr_t'(1);
            if (pop)    rd_ptr_d = rd_ptr_q + ptr_t'(1);
            count_d = count_q + cnt_t'(accept) - cnt_t'(pop);
        end
    end

    // State registers and entry storage. Reset clears the entry storage as
    // well, so that nothing stale ever reaches the outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_cnt_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                valid_q[k]        <= 1'b0;
                done_q[k]         <= 1'b0;
                ctrl_q[k]         <= '0;
                dest_q[k]         <= '0;
                gr_we_q[k]        <= 1'b0;
                alu_result_q[k]   <= '0;
                mem_access_q[k]   <= 1'b0;
                res_from_mem_q[k] <= 1'b0;
                load_op_q[k]      <= '0;
                rt_q[k]           <= '0;
                rdata_q[k]        <= '0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
            if (flush) begin
                for (int k = 0; k < DEPTH; k++) begin
                    valid_q[k] <= 1'b0;
                end
            end else begin
                if (accept) begin
                    valid_q[wr_ptr_q]        <= 1'b1;
                    done_q[wr_ptr_q]         <= 1'b0;
                    ctrl_q[wr_ptr_q]         <= in_ctrl;
                    dest_q[wr_ptr_q]         <= in_dest;
                    gr_we_q[wr_ptr_q]        <= in_gr_we;
                    alu_result_q[wr_ptr_q]   <= in_alu_result;
                    mem_access_q[wr_ptr_q]   <= in_mem_access;
                    res_from_mem_q[wr_ptr_q] <= in_res_from_mem;
                    load_op_q[wr_ptr_q]      <= in_load_op;
                    rt_q[wr_ptr_q]           <= in_rt;
                end
                if (absorb_entry) begin
                    rdata_q[rsp_ptr] <= data_sram_rdata;
                    done_q[rsp_ptr]  <= 1'b1;
                end
                if (pop) begin
                    valid_q[rd_ptr_q] <= 1'b0;
                end
            end
        end
    end

    // Head outputs, zeroed whenever the head is not ready
    always_comb begin
        ms_to_ws_valid = head_ready;
        out_ctrl       = '0;
        out_dest       = '0;
        out_gr_we      = 1'b0;
        out_result     = '0;
        if (head_ready) begin
            out_ctrl   = ctrl_q[rd_ptr_q];
            out_dest   = dest_q[rd_ptr_q];
            out_gr_we  = gr_we_q[rd_ptr_q];
            out_result = load_result(res_from_mem_q[rd_ptr_q], load_op_q[rd_ptr_q],
                                     alu_result_q[rd_ptr_q], rdata_q[rd_ptr_q], rt_q[rd_ptr_q]);
        end
    end

`ifdef MEM_FWD_EN
    ptr_t fwd_idx;
    ptr_t fwd_scan;
    logic fwd_found;

    // The youngest writer wins, so the scan keeps the last match in age order
    always_comb begin
        fwd_idx   = '0;
        fwd_scan  = '0;
        fwd_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_scan = rd_ptr_q + AW'(i);
            if (valid_q[fwd_scan] && gr_we_q[fwd_scan]) begin
                fwd_idx   = fwd_scan;
                fwd_found = 1'b1;
            end
        end
        MEM_dest      = '0;
        MEM_dest_data = '0;
        MEM_dest_ok   = 1'b0;
        if (fwd_found) begin
            MEM_dest      = dest_q[fwd_idx];
            MEM_dest_data = load_result(res_from_mem_q[fwd_idx], load_op_q[fwd_idx],
                                        alu_result_q[fwd_idx], rdata_q[fwd_idx], rt_q[fwd_idx]);
            MEM_dest_ok   = !mem_access_q[fwd_idx] || done_q[fwd_idx];
        end
    end
`else
    // Without forwarding, decode resolves dependences through WB only
    assign MEM_dest      = '0;
    assign MEM_dest_data = '0;
    assign MEM_dest_ok   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_resp_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_resp_stage
//
// Scoreboard bench for mem_resp_stage. Expected retirements are queued when
// instructions are offered. They are compared when the stage hands an entry
// to WB. Load results come from an independent shift/mask model of the MIPS
// load semantics.
// ---------------------------------------------------------------------------
module tb_mem_resp_stage;

    localparam int DEPTH  = 4;
    localparam int CTRL_W = 71;

    logic              clk;
    logic              reset;
    logic              es_to_ms_valid;
    logic              ms_allowin;
    logic [CTRL_W-1:0] in_ctrl;
    logic [4:0]        in_dest;
    logic              in_gr_we;
    logic [31:0]       in_alu_result;
    logic              in_mem_access;
    logic              in_res_from_mem;
    logic [2:0]        in_load_op;
    logic [31:0]       in_rt;
    logic              flush;
    logic              data_sram_data_ok;
    logic [31:0]       data_sram_rdata;
    logic              ms_to_ws_valid;
    logic              ws_allowin;
    logic [CTRL_W-1:0] out_ctrl;
    logic [4:0]        out_dest;
    logic              out_gr_we;
    logic [31:0]       out_result;
    logic [4:0]        MEM_dest;
    logic [31:0]       MEM_dest_data;
    logic              MEM_dest_ok;

    typedef struct packed {
        logic [4:0]        dest;
        logic [31:0]       result;
        logic [CTRL_W-1:0] ctrl;
    } expEntry_t;

    expEntry_t sb[$];
    expEntry_t monEntry;
    int        vectorsApplied = 0;
    int        miscompares    = 0;
    int        ctrlTag        = 0;

    mem_resp_stage #(.DEPTH(DEPTH), .CTRL_W(CTRL_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .es_to_ms_valid    (es_to_ms_valid),
        .ms_allowin        (ms_allowin),
        .in_ctrl           (in_ctrl),
        .in_dest           (in_dest),
        .in_gr_we          (in_gr_we),
        .in_alu_result     (in_alu_result),
        .in_mem_access     (in_mem_access),
        .in_res_from_mem   (in_res_from_mem),
        .in_load_op        (in_load_op),
        .in_rt             (in_rt),
        .flush             (flush),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ws_allowin        (ws_allowin),
        .out_ctrl          (out_ctrl),
        .out_dest          (out_dest),
        .out_gr_we         (out_gr_we),
        .out_result        (out_result),
        .MEM_dest          (MEM_dest),
        .MEM_dest_data     (MEM_dest_data),
        .MEM_dest_ok       (MEM_dest_ok)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net in case some wait never completes
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point for every check in the bench
    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        vectorsApplied++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Independent reference for the load result, built from shifts and masks
    function automatic logic [31:0] modelLoad(input logic [2:0] op, input logic [31:0] alu,
                                              input logic [31:0] rd, input logic [31:0] rt,
                                              input logic fromMem);
        int          sh;
        logic [7:0]  b;
        logic [15:0] h;
        if (!fromMem) return alu;
        sh = 8 * int'(alu[1:0]);
        b  = 8'(rd >> sh);
        h  = 16'(rd >> (16 * int'(alu[1])));
        case (op)
            3'd1:    return {{24{b[7]}}, b};
            3'd2:    return {24'd0, b};
            3'd3:    return {{16{h[15]}}, h};
            3'd4:    return {16'd0, h};
            3'd5:    return (rd << (24 - sh)) | (rt & (32'hFFFF_FFFF >> (sh + 8)));
            3'd6:    return (rd >> sh) | (rt & ~(32'hFFFF_FFFF >> sh));
            default: return rd;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one instruction for one cycle. Its expected retirement is queued
    // when it is meant to reach WB.
    task automatic applyStimulus(input logic [4:0] dest, input logic [31:0] alu,
                                 input logic memAcc, input logic fromMem,
                                 input logic [2:0] op, input logic [31:0] rt,
                                 input logic [31:0] expResult, input logic expRetire);
        expEntry_t e;
        ctrlTag++;
        es_to_ms_valid  = 1'b1;
        in_ctrl         = CTRL_W'(ctrlTag);
        in_dest         = dest;
        in_gr_we        = 1'b1;
        in_alu_result   = alu;
        in_mem_access   = memAcc;
        in_res_from_mem = fromMem;
        in_load_op      = op;
        in_rt           = rt;
        checkOutput("allowinOnOffer", ms_allowin, 1);
        if (expRetire) begin
            e.dest   = dest;
            e.result = expResult;
            e.ctrl   = CTRL_W'(ctrlTag);
            sb.push_back(e);
        end
        tick();
        es_to_ms_valid  = 1'b0;
        in_mem_access   = 1'b0;
        in_res_from_mem = 1'b0;
    endtask

    task automatic sendResp(input logic [31:0] data);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = data;
        tick();
        data_sram_data_ok = 1'b0;
    endtask

    task automatic waitDrain(input int maxCycles);
        int n;
        n = 0;
        while (sb.size() != 0 && n < maxCycles) begin
            tick();
            n++;
        end
        checkOutput("drainDone", 128'(sb.size()), 0);
    endtask

    // WB side: every handoff must match the oldest queued expectation
    always @(negedge clk) begin
        if (!reset && ms_to_ws_valid && ws_allowin) begin
            if (sb.size() == 0) begin
                checkOutput("unexpectedRetire", {out_dest, out_result}, 0);
            end else begin
                monEntry = sb.pop_front();
                checkOutput("retireDest", out_dest, monEntry.dest);
                checkOutput("retireResult", out_result, monEntry.result);
                checkOutput("retireCtrl", out_ctrl, monEntry.ctrl);
                checkOutput("retireGrWe", out_gr_we, 1);
            end
        end
    end

    logic [31:0] fillData [4];
    logic [2:0]  fillOp   [4];
    logic [31:0] fillAlu  [4];

    initial begin
        reset             = 1'b1;
        es_to_ms_valid    = 1'b0;
        in_ctrl           = '0;
        in_dest           = '0;
        in_gr_we          = 1'b0;
        in_alu_result     = '0;
        in_mem_access     = 1'b0;
        in_res_from_mem   = 1'b0;
        in_load_op        = '0;
        in_rt             = '0;
        flush             = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
        ws_allowin        = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state
        checkOutput("rstAllowin", ms_allowin, 1);
        checkOutput("rstValid", ms_to_ws_valid, 0);
        checkOutput("rstOutResult", out_result, 0);
        checkOutput("rstOutDest", out_dest, 0);
        checkOutput("rstOutGrWe", out_gr_we, 0);
        checkOutput("rstOutCtrl", out_ctrl, 0);
        checkOutput("rstMemDest", {MEM_dest, MEM_dest_data, MEM_dest_ok}, 0);
        checkOutput("rstDropCnt", dut.drop_cnt_q, 0);

        // ALU op is ready the cycle after acceptance
        ws_allowin = 1'b1;
        applyStimulus(5'd5, 32'h0000_1234, 1'b0, 1'b0, 3'd0, 32'd0, 32'h0000_1234, 1'b1);
        checkOutput("aluValidNext", ms_to_ws_valid, 1);
        checkOutput("aluResult", out_result, 32'h0000_1234);
        tick();
        checkOutput("aluPopped", ms_to_ws_valid, 0);

        // LB offset 3 is held under WB back-pressure, then pops exactly once
        ws_allowin = 1'b0;
        applyStimulus(5'd7, 32'h0000_1003, 1'b1, 1'b1, 3'd1, 32'd0, 32'hFFFF_FF80, 1'b1);
        checkOutput("lbWaitsForData", ms_to_ws_valid, 0);
        sendResp(32'h80FF_0011);
        for (int i = 0; i < 3; i++) begin
            checkOutput("lbHeldValid", ms_to_ws_valid, 1);
            checkOutput("lbHeldResult", out_result, 32'hFFFF_FF80);
            tick();
        end
        ws_allowin = 1'b1;
        tick();
        checkOutput("lbPoppedOnce", ms_to_ws_valid, 0);
        checkOutput("lbSbEmpty", 128'(sb.size()), 0);

        // Unaligned merges
        applyStimulus(5'd8, 32'h0000_2001, 1'b1, 1'b1, 3'd5, 32'hAABB_CCDD, 32'h3344_CCDD, 1'b1);
        sendResp(32'h1122_3344);
        applyStimulus(5'd9, 32'h0000_2002, 1'b1, 1'b1, 3'd6, 32'hAABB_CCDD, 32'hAABB_1122, 1'b1);
        sendResp(32'h1122_3344);
        waitDrain(10);

        // Fill all entries without responses, then retire them in order
        fillData[0] = 32'hCAFE_BABE; fillOp[0] = 3'd0; fillAlu[0] = 32'h0000_3000;
        fillData[1] = 32'h12F4_5678; fillOp[1] = 3'd2; fillAlu[1] = 32'h0000_3006;
        fillData[2] = 32'h8001_7FFF; fillOp[2] = 3'd3; fillAlu[2] = 32'h0000_300A;
        fillData[3] = 32'hFFFF_8000; fillOp[3] = 3'd4; fillAlu[3] = 32'h0000_300C;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(5'(10 + i), fillAlu[i], 1'b1, 1'b1, fillOp[i], 32'd0,
                          modelLoad(fillOp[i], fillAlu[i], fillData[i], 32'd0, 1'b1), 1'b1);
        end
        checkOutput("fullAllowin", ms_allowin, 0);
        checkOutput("fullNoValid", ms_to_ws_valid, 0);
        for (int i = 0; i < 4; i++) sendResp(fillData[i]);
        waitDrain(10);

        // Flush with two loads pending: their two responses must be swallowed
        applyStimulus(5'd20, 32'h0000_4000, 1'b1, 1'b1, 3'd0, 32'd0, 32'd0, 1'b0);
        applyStimulus(5'd21, 32'h0000_4004, 1'b1, 1'b1, 3'd0, 32'd0, 32'd0, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("flushEmpty", ms_to_ws_valid, 0);
        checkOutput("flushDropCnt", dut.drop_cnt_q, 2);
        applyStimulus(5'd22, 32'h0000_0100, 1'b1, 1'b1, 3'd0, 32'd0, 32'hC0DE_0003, 1'b1);
        sendResp(32'hDEAD_0001);
        sendResp(32'hDEAD_0002);
        checkOutput("droppedNotRetired", ms_to_ws_valid, 0);
        sendResp(32'hC0DE_0003);
        waitDrain(10);

        // Flush coincident with a response and an offered memory entry
        applyStimulus(5'd23, 32'h0000_5000, 1'b1, 1'b1, 3'd0, 32'd0, 32'd0, 1'b0);
        applyStimulus(5'd24, 32'h0000_5004, 1'b1, 1'b1, 3'd0, 32'd0, 32'd0, 1'b0);
        flush             = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h5555_0000;
        es_to_ms_valid    = 1'b1;
        in_mem_access     = 1'b1;
        in_res_from_mem   = 1'b1;
        in_dest           = 5'd25;
        checkOutput("coincidentAllowin", ms_allowin, 1);
        tick();
        flush             = 1'b0;
        data_sram_data_ok = 1'b0;
        es_to_ms_valid    = 1'b0;
        in_mem_access     = 1'b0;
        in_res_from_mem   = 1'b0;
        checkOutput("coincidentDropCnt", dut.drop_cnt_q, 2);
        checkOutput("coincidentEmpty", ms_to_ws_valid, 0);
        sendResp(32'h5555_0001);
        sendResp(32'h5555_0002);
        checkOutput("coincidentDrained", dut.drop_cnt_q, 0);
        checkOutput("coincidentNoRetire", ms_to_ws_valid, 0);

        // Mixed traffic with occasional WB stalls, wrapping the pointers
        for (int i = 0; i < 12; i++) begin
            logic        isMem;
            logic        fromMem;
            logic [2:0]  op;
            logic [31:0] alu;
            logic [31:0] rd;
            logic [31:0] rt;
            isMem      = ($urandom_range(0, 2) != 0);
            fromMem    = isMem && ($urandom_range(0, 3) != 0);
            op         = 3'($urandom_range(0, 7));
            alu        = $urandom;
            rd         = $urandom;
            rt         = $urandom;
            ws_allowin = (i % 3 != 2);
            applyStimulus(5'($urandom_range(1, 31)), alu, isMem, fromMem, op, rt,
                          modelLoad(op, alu, rd, rt, fromMem), 1'b1);
            if (isMem) sendResp(rd);
        end
        ws_allowin = 1'b1;
        waitDrain(50);

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_resp_stage.md
# mem_resp_stage

Parametrised memory-response stage of the five-stage MIPS pipeline, sitting between EX and WB in place of the single-entry MEM stage. It holds up to `DEPTH` in-order instructions whose data-SRAM requests have been issued, captures `data_sram_data_ok` responses even while WB back-pressures, and extracts load results (LW/LB/LBU/LH/LHU/LWL/LWR) per entry. On a pipeline flush it discards queued entries and silently drains responses still owed by the memory.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `CTRL_W`, 71: opaque per-instruction side-band (pc, ex_code, eret, slot, BadVAddr, pc_error), passed through untouched.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `es_to_ms_valid`  in  1  EX offers an instruction.
- `ms_allowin`  out  1  stage accepts this cycle.
- `in_ctrl`  in  CTRL_W  side-band.
- `in_dest`  in  5  destination register.
- `in_gr_we`  in  1  register write enable.
- `in_alu_result`  in  32  ALU result / effective address; bits [1:0] give byte offset.
- `in_mem_access`  in  1  a data-SRAM request was accepted with this instruction; one `data_ok` is owed.
- `in_res_from_mem`  in  1  writeback value comes from memory.
- `in_load_op`  in  3  0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LWL, 6 LWR, 7 treated as LW.
- `in_rt`  in  32  old rt value for LWL/LWR merge.
- `flush`  in  1  exception/ERET from WB; kill all entries.
- `data_sram_data_ok`  in  1  one response, in request order.
- `data_sram_rdata`  in  32  response data.
- `ms_to_ws_valid`  out  1  head entry ready for WB.
- `ws_allowin`  in  1  WB accepts.
- `out_ctrl`  out  CTRL_W; `out_dest`  out  5; `out_gr_we`  out  1; `out_result`  out  32  head entry fields.
- `MEM_dest`  out  5; `MEM_dest_data`  out  32; `MEM_dest_ok`  out  1  forwarding (see Configuration).

## Operation
- Circular queue: `wr_ptr`, `rd_ptr`, `rsp_ptr` (oldest entry still awaiting `data_ok`), `count`, `drop_cnt`.
- Accept when `es_to_ms_valid && ms_allowin && !flush`: write entry at `wr_ptr`, `done=0`.
- `ms_allowin = (count < DEPTH) && (pending + drop_cnt < DEPTH)`, where `pending` = entries with `mem_access && !done`.
- `data_sram_data_ok` with `drop_cnt>0`: decrement `drop_cnt`, data discarded. Otherwise: store rdata into entry `rsp_ptr`, set `done`, and advance `rsp_ptr` past the next entries without `mem_access`.
- `data_ok` with neither drop nor pending is a protocol error and is ignored.
- Head ready = valid && (`!mem_access || done`). Pop on `ms_to_ws_valid && ws_allowin`.
- Result: if `res_from_mem`, extract from stored rdata with `ofs = alu_result[1:0]`.
  - LB/LBU: byte `ofs`, sign- or zero-extended.
  - LH/LHU: halfword `ofs[1]`, sign- or zero-extended.
  - LWL: ofs 0 `{rd[7:0],rt[23:0]}`, 1 `{rd[15:0],rt[15:0]}`, 2 `{rd[23:0],rt[7:0]}`, 3 `rd`.
  - LWR: ofs 0 `rd`, 1 `{rt[31:24],rd[31:8]}`, 2 `{rt[31:16],rd[31:16]}`, 3 `{rt[31:8],rd[31:24]}`.
  - Otherwise: `alu_result`.
- Flush: all entries invalidated, pointers and count reset. `drop_cnt += pending` (including a same-cycle offered entry with `in_mem_access`), minus 1 if a same-cycle `data_ok` is not already absorbed by `drop_cnt`.

## Timing
- Reset values: `ms_allowin` 1, `ms_to_ws_valid` 0, all `out_*` 0, `MEM_*` 0, `drop_cnt` 0.
- Non-memory entry: `ms_to_ws_valid` is asserted the cycle after acceptance.
- Memory entry: `ms_to_ws_valid` is asserted the cycle after its `data_ok` (registered; no combinational rdata path to outputs).
- Full: accept and pop in the same cycle are allowed only when `count<DEPTH`. There is no bypass when full.
- Pointers wrap modulo DEPTH.
- `out_dest`/`out_gr_we` are 0 when `!ms_to_ws_valid`.
- Flush takes effect at the next edge; outputs are invalid the cycle after.
- Reset mid-operation clears `drop_cnt`. Memory must also be reset.

## Configuration
- `MEM_FWD_EN` defined:
  - `MEM_dest` = dest of the youngest valid entry with `gr_we`, else 0.
  - `MEM_dest_data` = its extracted result.
  - `MEM_dest_ok` = that entry is ready.
- Not defined: all three outputs are tied to 0. Decode then stalls on the WB dependence only.

## Test plan
- Reset, then ALU op dest 5, result 0x1234 → `ms_to_ws_valid` next cycle, `out_result=0x1234`, `out_dest=5`.
- LB ofs 3, rdata 0x80FF_0011, `ws_allowin=0` for 3 cycles → held, then result 0xFFFF_FF80 popped once.
- LWL ofs 1, rt 0xAABB_CCDD, rdata 0x1122_3344 → 0x3344_CCDD; LWR ofs 2, same operands → 0xAABB_1122.
- Fill DEPTH=4 loads with no `data_ok` → `ms_allowin=0`; four `data_ok` responses → results retire in order.
- Two loads pending, `flush` → queue empty; next two `data_ok` discarded; a new load's `data_ok` (third) returns its correct data.
- Flush coincident with `data_ok` and an offered memory entry → `drop_cnt=2` (two pending −1 +1 offered); nothing reaches WB.
